// File: rtl/ray_setup_if.sv
// ray_setup_if -- handshake/data bundle between a ray producer and ray_setup.
//   in_valid / in_ready : input ray handshake
//   in_orig, in_dir     : vec3 origin / direction, index 0 = x, 1 = y, 2 = z
//   in_tmin, in_tmax    : requested t-range
//   out_valid/out_ready : result handshake
//   ray_orig            : registered origin
//   inv_ray_dir         : per-component fixed-point reciprocal of in_dir
//   range_out           : starting range, index 0 = min, 1 = max
// Modports: master = ray producer / result consumer side, slave = ray_setup.
interface ray_setup_if #(
  parameter int W = 24
) ();
  logic                in_valid;
  logic                in_ready;
  logic [2:0][W-1:0]   in_orig;
  logic [2:0][W-1:0]   in_dir;
  logic [W-1:0]        in_tmin;
  logic [W-1:0]        in_tmax;
  logic                out_valid;
  logic                out_ready;
  logic [2:0][W-1:0]   ray_orig;
  logic [2:0][W-1:0]   inv_ray_dir;
  logic [1:0][W-1:0]   range_out;

  modport master (
    output in_valid, in_orig, in_dir, in_tmin, in_tmax, out_ready,
    input  in_ready, out_valid, ray_orig, inv_ray_dir, range_out
  );

  modport slave (
    input  in_valid, in_orig, in_dir, in_tmin, in_tmax, out_ready,
    output in_ready, out_valid, ray_orig, inv_ray_dir, range_out
  );
endinterface

// File: rtl/ray_setup.sv
// ray_setup -- front end of the traversal datapath.
// Accepts one ray (origin, direction, t-range), computes the fixed-point
// reciprocal of each direction component with a sequential restoring divider
// (2^(2*FRAC_BITS) / |d|, one quotient bit per cycle, x then y then z) and
// presents origin, reciprocal direction and clipped range on a valid/ready
// handshake. One ray in flight; latency 3*(2*FRAC_BITS+1)+1 edges, fixed.
// Ports:
//   sysclk   : clock, rising edge
//   rst      : synchronous reset, active high
//   bus      : ray_setup_if.slave (input ray handshake + result handshake)
//   dir_sign : (only with RAY_SETUP_DIRSIGN_EN) per-axis sign of in_dir,
//              bit0 = x, bit1 = y, bit2 = z, 1 = negative
// Optional feature macro: RAY_SETUP_DIRSIGN_EN.
module ray_setup #(
  parameter int W         = 24,
  parameter int FRAC_BITS = 12
) (
  input  logic       sysclk,
  input  logic       rst,
`ifdef RAY_SETUP_DIRSIGN_EN
  output logic [2:0] dir_sign,
`endif
  ray_setup_if.slave bus
);

  localparam int QW   = 2 * FRAC_BITS + 1;            // quotient bits per axis
  localparam int CW   = $clog2(QW);
  localparam int CMPW = (QW > W) ? QW : W;
  localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);
  localparam logic [W-1:0]  SAT_MAX  = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [2:0][W-1:0] orig_q;
  logic [2:0][W-1:0] dir_q;
  logic [2:0][W-1:0] inv_q;
  logic [1:0][W-1:0] range_q;
  logic [1:0]        axis_q;
  logic [CW-1:0]     cnt_q;
  logic [W-1:0]      rem_q;
  logic [QW-2:0]     quo_q;
  logic              last_q;    // z written, next edge enters DONE
`ifdef RAY_SETUP_DIRSIGN_EN
  logic [2:0]        dir_sign_q;
`endif

  logic [W-1:0]      cur_dir_s;
  logic              dir_neg_s;
  logic              dir_zero_s;
  logic [W-1:0]      mag_s;
  logic [W:0]        trial_s;
  logic [W:0]        diff_s;
  logic              qbit_s;
  logic [W-1:0]      rem_d;
  logic [QW-1:0]     quo_full_s;
  logic [QW-2:0]     quo_d;
  logic [CMPW-1:0]   quo_ext_s;
  logic [W-1:0]      mag_sat_s;
  logic [W-1:0]      result_s;

  // One restoring-division step for the current axis plus the signed, saturated result.
  always_comb begin
    cur_dir_s = dir_q[0];
    case (axis_q)
      2'd0:    cur_dir_s = dir_q[0];
      2'd1:    cur_dir_s = dir_q[1];
      2'd2:    cur_dir_s = dir_q[2];
      default: cur_dir_s = dir_q[0];
    endcase
    dir_neg_s  = cur_dir_s[W-1];
    dir_zero_s = (cur_dir_s == {W{1'b0}});
    // -(2^(W-1)) wraps to itself, which read unsigned is exactly 2^(W-1)
    if (dir_neg_s) begin
      mag_s = -cur_dir_s;
    end else begin
      mag_s = cur_dir_s;
    end
    // The dividend is a single 1 at its MSB, so only the first step shifts in a 1
    trial_s = {rem_q, (cnt_q == {CW{1'b0}})};
    diff_s  = trial_s - {1'b0, mag_s};
    // trial < 2*|d|, so bit W of the difference is a clean borrow flag
    qbit_s  = ~diff_s[W];
    if (qbit_s) begin
      rem_d = diff_s[W-1:0];
    end else begin
      rem_d = trial_s[W-1:0];
    end
    quo_full_s = {quo_q, qbit_s};
    quo_d      = quo_full_s[QW-2:0];
    quo_ext_s  = CMPW'(quo_full_s);
    if (quo_ext_s > CMPW'(SAT_MAX)) begin
      mag_sat_s = SAT_MAX;
    end else begin
      mag_sat_s = quo_ext_s[W-1:0];
    end
    // Division by zero still ran its cycles; its quotient is replaced here
    if (dir_zero_s) begin
      result_s = SAT_MAX;
    end else if (dir_neg_s) begin
      result_s = -mag_sat_s;
    end else begin
      result_s = mag_sat_s;
    end
  end

  // Control FSM, divider state and all registered outputs.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      orig_q      <= '0;
      dir_q       <= '0;
      inv_q       <= '0;
      range_q     <= '0;
      axis_q      <= 2'd0;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= {W{1'b0}};
      quo_q       <= '0;
      last_q      <= 1'b0;
`ifdef RAY_SETUP_DIRSIGN_EN
      dir_sign_q  <= 3'b000;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            orig_q     <= bus.in_orig;
            dir_q      <= bus.in_dir;
            range_q[0] <= bus.in_tmin[W-1] ? {W{1'b0}} : bus.in_tmin;
            range_q[1] <= bus.in_tmax;
            axis_q     <= 2'd0;
            cnt_q      <= {CW{1'b0}};
            rem_q      <= {W{1'b0}};
            quo_q      <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= DIV;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DIV: begin
          if (last_q) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == LAST_CNT) begin
            case (axis_q)
              2'd0:    inv_q[0] <= result_s;
              2'd1:    inv_q[1] <= result_s;
              default: inv_q[2] <= result_s;
            endcase
`ifdef RAY_SETUP_DIRSIGN_EN
            case (axis_q)
              2'd0:    dir_sign_q[0] <= dir_neg_s;
              2'd1:    dir_sign_q[1] <= dir_neg_s;
              default: dir_sign_q[2] <= dir_neg_s;
            endcase
`endif
            cnt_q <= {CW{1'b0}};
            rem_q <= {W{1'b0}};
            quo_q <= '0;
            if (axis_q == 2'd2) begin
              last_q <= 1'b1;
            end else begin
              axis_q <= axis_q + 2'd1;
            end
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.ray_orig    = orig_q;
  assign bus.inv_ray_dir = inv_q;
  assign bus.range_out   = range_q;
`ifdef RAY_SETUP_DIRSIGN_EN
  assign dir_sign = dir_sign_q;
`endif

endmodule

// File: tb/tb_ray_setup.sv
module tb_ray_setup;
  localparam int W   = 24;
  localparam int F   = 12;
  localparam int LAT = 3 * (2 * F + 1) + 1;   // 76

  typedef struct {
    logic [2:0][W-1:0] orig;
    logic [2:0][W-1:0] dir;
    logic [2:0][W-1:0] inv;
    logic [W-1:0]      rmin;
    logic [W-1:0]      rmax;
    int                exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ray_setup_if #(.W(W)) bus ();
`ifdef RAY_SETUP_DIRSIGN_EN
  logic [2:0] dir_sign;
`endif

  ray_setup #(.W(W), .FRAC_BITS(F)) dut (
    .sysclk   (clk),
    .rst      (rst),
`ifdef RAY_SETUP_DIRSIGN_EN
    .dir_sign (dir_sign),
`endif
    .bus      (bus.slave)
  );

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rst_prev = 1'b0;
  bit   hs_pending = 1'b0;
  bit   front_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference reciprocal: floor(2^24 / |d|), saturated, sign restored.
  function automatic logic [W-1:0] ref_inv(input logic [W-1:0] d);
    longint mag;
    longint qv;
    if (d == 24'd0) return 24'h7FFFFF;
    mag = d[W-1] ? (64'sd16777216 - longint'(d)) : longint'(d);
    qv  = 64'sd16777216 / mag;
    if (qv > 64'sd8388607) qv = 64'sd8388607;
    return d[W-1] ? 24'(64'sd16777216 - qv) : 24'(qv);
  endfunction

  // Compare process: checks every cycle against the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (hs_pending) begin
        if (q.size() > 0) void'(q.pop_front());
        hs_pending = 1'b0;
        front_seen = 1'b0;
      end
      if (rst_prev) begin
        check("rst_out_valid", 80'(bus.out_valid), 80'd0);
        check("rst_in_ready", 80'(bus.in_ready), 80'd0);
        check("rst_ray_orig", 80'(bus.ray_orig), 80'd0);
        check("rst_inv_dir", 80'(bus.inv_ray_dir), 80'd0);
        check("rst_range", 80'(bus.range_out), 80'd0);
`ifdef RAY_SETUP_DIRSIGN_EN
        check("rst_dir_sign", 80'(dir_sign), 80'd0);
`endif
      end else if (!rst) begin
        check("in_ready", 80'(bus.in_ready), 80'(q.size() == 0));
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check("spurious_out_valid", 80'd1, 80'd0);
          end else begin
            if (!front_seen) begin
              check("latency", 80'(cyc), 80'(q[0].exp_cyc));
              front_seen = 1'b1;
            end
            check("ray_orig", 80'(bus.ray_orig), 80'(q[0].orig));
            check("inv_ray_dir", 80'(bus.inv_ray_dir), 80'(q[0].inv));
            check("range_out", 80'(bus.range_out), 80'({q[0].rmax, q[0].rmin}));
`ifdef RAY_SETUP_DIRSIGN_EN
            check("dir_sign", 80'(dir_sign),
                  80'({q[0].dir[2][W-1], q[0].dir[1][W-1], q[0].dir[0][W-1]}));
`endif
            if (bus.out_ready) hs_pending = 1'b1;
          end
        end else if (q.size() > 0 && front_seen) begin
          check("out_valid_dropped", 80'd0, 80'd1);
          front_seen = 1'b0;
          void'(q.pop_front());
        end else if (q.size() > 0 && cyc >= q[0].exp_cyc) begin
          check("late_out_valid", 80'(cyc), 80'(q[0].exp_cyc));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [2:0][W-1:0] orig, input logic [2:0][W-1:0] dir,
                      input logic [W-1:0] tmin, input logic [W-1:0] tmax,
                      input logic [2:0][W-1:0] inv);
    int   guard;
    exp_t e;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!bus.in_ready && guard < 300);
    if (!bus.in_ready) begin
      check("in_ready_timeout", 80'd0, 80'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_orig  = orig;
    bus.in_dir   = dir;
    bus.in_tmin  = tmin;
    bus.in_tmax  = tmax;
    @(posedge clk); #1;
    e.orig    = orig;
    e.dir     = dir;
    e.inv     = inv;
    e.rmin    = tmin[W-1] ? 24'd0 : tmin;
    e.rmax    = tmax;
    e.exp_cyc = cyc + LAT;
    q.push_back(e);
    bus.in_valid = 1'b0;
    // inputs need not stay stable after acceptance
    bus.in_orig  = {24'($urandom), 24'($urandom), 24'($urandom)};
    bus.in_dir   = {24'($urandom), 24'($urandom), 24'($urandom)};
    bus.in_tmin  = 24'($urandom);
    bus.in_tmax  = 24'($urandom);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 80'd0, 80'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((q.size() > 0 || hs_pending) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) begin
      check("drain_timeout", 80'(q.size()), 80'd0);
      q.delete();
      front_seen = 1'b0;
    end
  endtask

  task automatic pulse_in_valid();
    bus.in_valid = 1'b1;
    bus.in_orig  = {24'hABCDEF, 24'h123456, 24'h654321};
    bus.in_dir   = {24'h000100, 24'h000200, 24'h000300};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_dir();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = 24'($urandom);
      1:       v = 24'($urandom_range(0, 16));
      2:       v = 24'd0;
      3:       v = 24'h800000;
      default: v = 24'($urandom_range(1, 24'h3000));
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    logic [2:0][W-1:0] d;
    logic [2:0][W-1:0] o;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_orig  = '0;
    bus.in_dir   = '0;
    bus.in_tmin  = '0;
    bus.in_tmax  = '0;
    bus.out_ready = 1'b1;

    // pin the model against hand-computed values
    check("model_1p0", 80'(ref_inv(24'h001000)), 80'h001000);
    check("model_12p0", 80'(ref_inv(24'h00C000)), 80'h000155);
    check("model_m0p5", 80'(ref_inv(24'hFFF800)), 80'hFFE000);
    check("model_m1lsb", 80'(ref_inv(24'hFFFFFF)), 80'h800001);
    check("model_zero", 80'(ref_inv(24'h000000)), 80'h7FFFFF);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // directed vectors with literal expectations (index 0 = x)
    send({24'd3, 24'd2, 24'd1}, {24'h00C000, 24'h002000, 24'h001000}, 24'h000000, 24'h010000,
         {24'h000155, 24'h000800, 24'h001000});
    wait_done(200);
    send({24'd9, 24'd8, 24'd7}, {24'h800000, 24'h003000, 24'hFFF800}, 24'h000100, 24'h000050,
         {24'hFFFFFE, 24'h000555, 24'hFFE000});
    wait_done(200);
    send({24'hFFFFFF, 24'h800000, 24'h7FFFFF}, {24'hFFFFFF, 24'h000001, 24'h000000},
         24'h7FFFFF, 24'h800000, {24'h800001, 24'h7FFFFF, 24'h7FFFFF});
    wait_done(200);
    send({24'd0, 24'd0, 24'd0}, {24'h800000, 24'h000000, 24'hFFF800}, 24'h000010, 24'h000020,
         {24'hFFFFFE, 24'h7FFFFF, 24'hFFE000});
    wait_done(200);

    // range clipping and a 10-cycle output stall with ignored input pulses
    bus.out_ready = 1'b0;
    d = {rand_dir(), rand_dir(), rand_dir()};
    send({24'd7, 24'd6, 24'd5}, d, 24'hFFF000, 24'h010000,
         {ref_inv(d[2]), ref_inv(d[1]), ref_inv(d[0])});
    repeat (20) @(posedge clk);
    #1 pulse_in_valid();
    wait_valid(200);
    repeat (4) @(posedge clk);
    #1 pulse_in_valid();
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done(200);

    // reset 30 cycles into a division, then a fresh ray
    d = {rand_dir(), rand_dir(), rand_dir()};
    send({24'd1, 24'd2, 24'd3}, d, 24'd0, 24'd100,
         {ref_inv(d[2]), ref_inv(d[1]), ref_inv(d[0])});
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    hs_pending = 1'b0;
    front_seen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    send({24'd4, 24'd5, 24'd6}, {24'h001000, 24'h001000, 24'h001000}, 24'd0, 24'd200,
         {24'h001000, 24'h001000, 24'h001000});
    wait_done(200);

    // randomized rays against the model, with random output back-pressure
    for (int i = 0; i < 20; i++) begin
      d = {rand_dir(), rand_dir(), rand_dir()};
      o = {24'($urandom), 24'($urandom), 24'($urandom)};
      bus.out_ready = i[0];
      send(o, d, 24'($urandom), 24'($urandom),
           {ref_inv(d[2]), ref_inv(d[1]), ref_inv(d[0])});
      if (!i[0]) begin
        wait_valid(200);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      wait_done(200);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
